// File: rtl/mandelbrot_pkg.sv
// Shared constants and state encoding for the Mandelbrot block requester.
package mandelbrot_pkg;
  localparam logic [7:0] CMD_RESET       = 8'h00;
  localparam logic [7:0] CMD_SEND_BUFFER = 8'h01;
  localparam int         FRAME_LEN       = 7;

  typedef enum logic [2:0] {IDLE, SEND, TX_HOLD, TX_WAIT, RECV} state_t;
endpackage

// File: rtl/block_requester_if.sv
// Block request channel: valid/ready handshake carrying the start coordinates.
interface block_requester_if #(parameter int N = 16);
  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] c_real;
  logic [N-1:0] c_imag;
  logic [N-1:0] c_step;

  modport master (output req_valid, c_real, c_imag, c_step, input req_ready);
  modport slave  (input req_valid, c_real, c_imag, c_step, output req_ready);
endinterface

// File: rtl/frame_serializer.sv
// Command frame byte sequencer: holds the byte index and muxes out the current byte.
module frame_serializer
  import mandelbrot_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_adv,
  input  logic [N-1:0] i_c_real,
  input  logic [N-1:0] i_c_imag,
  input  logic [N-1:0] i_c_step,
  output logic [7:0]   o_byte,
  output logic         o_frame_done
);
  logic [2:0]  r_idx;
  logic [15:0] w_cr, w_ci, w_cs;

  assign w_cr = 16'(i_c_real);
  assign w_ci = 16'(i_c_imag);
  assign w_cs = 16'(i_c_step);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_idx <= '0;
    else if (i_clr) r_idx <= '0;
    else if (i_adv) r_idx <= r_idx + 3'd1;
  end

  always_comb begin
    o_byte = 8'h00;
    case (r_idx)
      3'd0: o_byte = CMD_SEND_BUFFER;
      3'd1: o_byte = w_cr[15:8];
      3'd2: o_byte = w_cr[7:0];
      3'd3: o_byte = w_ci[15:8];
      3'd4: o_byte = w_ci[7:0];
      3'd5: o_byte = w_cs[15:8];
      3'd6: o_byte = w_cs[7:0];
      default: o_byte = 8'h00;
    endcase
  end

  // Index is advanced once per sent byte, so reaching FRAME_LEN means all bytes are out.
  assign o_frame_done = (r_idx == 3'(FRAME_LEN));
endmodule

// File: rtl/block_requester.sv
// Sends a 7-byte block command over UART, then streams BLOCK_SIZE^2 result bytes as pixels.
// Define REQ_TIMEOUT_EN to enable the receive watchdog (sticky error, aborts without done).
module block_requester
  import mandelbrot_pkg::*;
#(
  parameter int N              = 16,
  parameter int BLOCK_SIZE     = 64,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  block_requester_if.slave   req,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_active,
  input  logic [7:0]         rx_data,
  input  logic               rx_ready,
  output logic               pix_valid,
  output logic [7:0]         pix_x,
  output logic [7:0]         pix_y,
  output logic [7:0]         pix_count,
  output logic               busy,
  output logic               done,
  output logic               error
);
  localparam int PW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [PW-1:0] LAST = PW'(BLOCK_SIZE - 1);

  state_t        r_state;
  logic [N-1:0]  r_cr, r_ci, r_cs;
  logic [PW-1:0] r_col, r_row;
  logic [7:0]    w_byte;
  logic          w_frame_done;

`ifdef REQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wd;
`else
  assign error = 1'b0;
`endif

  frame_serializer #(.N(N)) u_ser (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr        (r_state == IDLE),
    .i_adv        (r_state == TX_HOLD),
    .i_c_real     (r_cr),
    .i_c_imag     (r_ci),
    .i_c_step     (r_cs),
    .o_byte       (w_byte),
    .o_frame_done (w_frame_done)
  );

  assign busy          = (r_state != IDLE);
  assign req.req_ready = (r_state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cr      <= '0;
      r_ci      <= '0;
      r_cs      <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_count <= '0;
      done      <= 1'b0;
      r_col     <= '0;
      r_row     <= '0;
`ifdef REQ_TIMEOUT_EN
      error     <= 1'b0;
      r_wd      <= '0;
`endif
    end else begin
      tx_start  <= 1'b0;
      pix_valid <= 1'b0;
      done      <= 1'b0;
      case (r_state)
        IDLE: if (req.req_valid) begin
          r_cr    <= req.c_real;
          r_ci    <= req.c_imag;
          r_cs    <= req.c_step;
`ifdef REQ_TIMEOUT_EN
          error   <= 1'b0;
`endif
          r_state <= SEND;
        end
        SEND: if (!tx_active) begin
          tx_data  <= w_byte;
          tx_start <= 1'b1;
          r_state  <= TX_HOLD;
        end
        // UART raises tx_active a cycle after the strobe; TX_HOLD covers that gap.
        TX_HOLD: r_state <= TX_WAIT;
        TX_WAIT: if (!tx_active) begin
          if (w_frame_done) begin
            r_col   <= '0;
            r_row   <= '0;
            pix_x   <= '0;
            pix_y   <= '0;
`ifdef REQ_TIMEOUT_EN
            r_wd    <= '0;
`endif
            r_state <= RECV;
          end else begin
            r_state <= SEND;
          end
        end
        RECV: begin
          if (rx_ready) begin
            pix_valid <= 1'b1;
            pix_count <= rx_data;
            pix_x     <= 8'(r_col);
            pix_y     <= 8'(r_row);
`ifdef REQ_TIMEOUT_EN
            r_wd      <= '0;
`endif
            if (r_col == LAST) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
              if (r_row == LAST) begin
                done    <= 1'b1;
                r_state <= IDLE;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
`ifdef REQ_TIMEOUT_EN
          else if (r_wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
            error   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_block_requester.sv
// Randomized scoreboard bench for block_requester: tx frame and pixel stream checked from queues.
module tb_block_requester;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_active = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       pix_valid, busy, done, error;
  logic [7:0] pix_x, pix_y, pix_count;

  block_requester_if #(.N(16)) rif ();

  block_requester #(.N(16), .BLOCK_SIZE(64), .TIMEOUT_CYCLES(100)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (rif),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_active (tx_active),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_count (pix_count),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] c;
    logic       last;
  } pix_t;

  logic [7:0] tx_q[$];
  pix_t       pix_q[$];
  int n_vec = 0;
  int n_err = 0;
  int tx_starts = 0;
  int tx_hold = 20;
  int pix_idx = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // UART transmitter model plus tx-side scoreboard checks.
  initial begin
    logic prev_st;
    int   hold;
    prev_st = 1'b0;
    hold = 0;
    forever begin
      @(posedge clk); #1;
      if (tx_start) begin
        tx_starts++;
        chk("tx_start_one_cycle", 32'(prev_st), 0);
        chk("tx_start_while_active", 32'(tx_active), 0);
        if (tx_q.size() == 0) chk("tx_unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
        else chk("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
        tx_active = 1'b1;
        hold = tx_hold;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) tx_active = 1'b0;
      end
      prev_st = tx_start;
    end
  end

  // Pixel monitor.
  initial begin
    pix_t p;
    forever begin
      @(negedge clk);
      if (pix_valid) begin
        if (pix_q.size() == 0) chk("pix_unexpected", {pix_x, pix_y, pix_count, 8'h00}, 32'hFFFF_FFFF);
        else begin
          p = pix_q.pop_front();
          chk("pix_x", 32'(pix_x), 32'(p.x));
          chk("pix_y", 32'(pix_y), 32'(p.y));
          chk("pix_count", 32'(pix_count), 32'(p.c));
          chk("done_with_pixel", 32'(done), 32'(p.last));
          chk("busy_after_pixel", 32'(busy), 32'(!p.last));
        end
      end else if (done) begin
        chk("done_without_pixel", 32'(done), 0);
      end
    end
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

  task automatic check_reset();
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_pix_xyc", {8'h00, pix_x, pix_y, pix_count}, 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(rif.req_ready), 1);
  endtask

  task automatic request(input logic [15:0] cr, input logic [15:0] ci, input logic [15:0] cs);
    int t;
    t = 0;
    while (!rif.req_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready_wait", 32'(rif.req_ready), 1);
    rif.c_real = cr;
    rif.c_imag = ci;
    rif.c_step = cs;
    rif.req_valid = 1'b1;
    tx_q.push_back(8'h01);
    tx_q.push_back(cr[15:8]);
    tx_q.push_back(cr[7:0]);
    tx_q.push_back(ci[15:8]);
    tx_q.push_back(ci[7:0]);
    tx_q.push_back(cs[15:8]);
    tx_q.push_back(cs[7:0]);
    pix_idx = 0;
    @(negedge clk);
    rif.req_valid = 1'b0;
    rif.c_real = 16'($urandom);
    rif.c_imag = 16'($urandom);
    rif.c_step = 16'($urandom);
  endtask

  task automatic wait_tx(input bit junk);
    int t;
    t = 0;
    while (tx_q.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
      rx_ready = junk && (t % 4 == 0);
      rx_data = 8'($urandom);
    end
    rx_ready = 1'b0;
    chk("tx_frame_drained", 32'(tx_q.size()), 0);
    t = 0;
    while (tx_active && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic feed(input int n, input bit directed, input int gapmax, input int req_at);
    pix_t p;
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(1, gapmax)) @(negedge clk);
      d = directed ? 8'(i % 256) : 8'($urandom);
      p.x = 8'(pix_idx % 64);
      p.y = 8'(pix_idx / 64);
      p.c = d;
      p.last = (pix_idx == 4095);
      pix_q.push_back(p);
      pix_idx++;
      rx_data = d;
      rx_ready = 1'b1;
      if (i == req_at) begin
        rif.req_valid = 1'b1;
        rif.c_real = 16'($urandom);
      end
      @(negedge clk);
      rx_ready = 1'b0;
      rif.req_valid = 1'b0;
    end
  endtask

  task automatic drain_pix();
    int t;
    t = 0;
    while (pix_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("pix_stream_drained", 32'(pix_q.size()), 0);
  endtask

  initial begin
    int base, t, n;
    rif.req_valid = 1'b0;
    rif.c_real = '0;
    rif.c_imag = '0;
    rif.c_step = '0;
    repeat (3) @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed frame with slow UART, ignored rx strobes during SEND and a req during RECV.
    tx_hold = 20;
    base = tx_starts;
    request(16'hF800, 16'hFC00, 16'h0010);
    wait_tx(1'b1);
    chk("tx_start_count", 32'(tx_starts - base), 7);
    chk("busy_in_recv", 32'(busy), 1);
    chk("req_ready_in_recv", 32'(rif.req_ready), 0);
    feed(4096, 1'b1, 1, 100);
    drain_pix();
    chk("idle_after_block", 32'(rif.req_ready), 1);
    chk("tx_no_extra_start", 32'(tx_starts - base), 7);

    // Random coordinates, random UART timing and random pixel data.
    tx_hold = $urandom_range(1, 5);
    request(16'($urandom), 16'($urandom), 16'($urandom));
    wait_tx(1'b0);
    feed(4096, 1'b0, 3, -1);
    drain_pix();
    chk("idle_after_block2", 32'(busy), 0);

    // Reset mid-frame after three bytes.
    tx_hold = 4;
    base = tx_starts;
    request(16'($urandom), 16'($urandom), 16'($urandom));
    t = 0;
    while (tx_starts - base < 3 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("three_bytes_sent", 32'(tx_starts - base), 3);
    rst_n = 1'b0;
    #1;
    check_reset();
    tx_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    request(16'hF800, 16'hFC00, 16'h0010);
    wait_tx(1'b0);

    // Stream stalls after 10 bytes.
    feed(10, 1'b0, 2, -1);
    n = 0;
`ifdef REQ_TIMEOUT_EN
    while (!error && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("timeout_cycle", 32'(n), 100);
    chk("timeout_error", 32'(error), 1);
    chk("timeout_req_ready", 32'(rif.req_ready), 1);
    repeat (5) @(negedge clk);
    chk("error_sticky", 32'(error), 1);
    request(16'h0001, 16'h0002, 16'h0003);
    chk("error_cleared", 32'(error), 0);
    tx_q.delete();
`else
    repeat (150) @(posedge clk);
    #1;
    chk("no_watchdog_error", 32'(error), 0);
    chk("recv_waits", 32'(busy), 1);
`endif
    drain_pix();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/block_requester.md
BLOCK_REQUESTER -- requirements
Module: block_requester

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- N, 16, fixed-point coordinate width
- BLOCK_SIZE, 64, pixels per row and per column
- TIMEOUT_CYCLES, 1000000, receive watchdog limit in clk cycles
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock
- rst_n, in, 1, asynchronous active-low reset
- req_valid, in, 1, block request offered
- req_ready, out, 1, block accepts a request
- c_real, in, N, start real coordinate
- c_imag, in, N, start imaginary coordinate
- c_step, in, N, pixel step
- tx_data, out, 8, byte to UART transmitter
- tx_start, out, 1, one-cycle transmit strobe
- tx_active, in, 1, UART transmitter busy
- rx_data, in, 8, byte from UART receiver
- rx_ready, in, 1, one-cycle receive-valid strobe
- pix_valid, out, 1, one-cycle pixel strobe
- pix_x, out, 8, pixel column
- pix_y, out, 8, pixel row
- pix_count, out, 8, iteration count (the received byte)
- busy, out, 1, transaction in progress
- done, out, 1, one-cycle strobe when the block completes
- error, out, 1, sticky watchdog abort flag

Function
REQ-003 The block SHALL implement exactly these states: IDLE, SEND, TX_HOLD, TX_WAIT, RECV.
REQ-004 In IDLE, req_ready SHALL be 1; when req_valid and req_ready are both 1, the block SHALL latch c_real, c_imag and c_step, clear error, and enter SEND.
REQ-005 The command frame SHALL be 7 bytes in this order: 0x01 (CMD_SEND_BUFFER), c_real[15:8], c_real[7:0], c_imag[15:8], c_imag[7:0], c_step[15:8], c_step[7:0].
REQ-006 In SEND with tx_active=0, the block SHALL drive tx_data with the current frame byte, pulse tx_start for one cycle, and enter TX_HOLD.
REQ-007 TX_HOLD SHALL last exactly one cycle, then go to TX_WAIT; TX_WAIT SHALL stay until tx_active=0.
REQ-008 From TX_WAIT, the block SHALL return to SEND while frame bytes remain, and enter RECV after byte 7 with pix_x=0 and pix_y=0.
REQ-009 rx_ready strobes outside RECV SHALL be ignored.
REQ-010 In RECV, each rx_ready SHALL cause pix_valid=1 on the next cycle, with pix_count=rx_data and the current pix_x/pix_y.
REQ-011 After each received byte, pix_x SHALL increment; at BLOCK_SIZE-1 it SHALL wrap to 0 and pix_y SHALL increment.
REQ-012 The byte at (BLOCK_SIZE-1, BLOCK_SIZE-1) SHALL produce its pix_valid, pulse done in the same cycle, and return the block to IDLE.
REQ-013 busy SHALL equal (state != IDLE); req_ready SHALL equal (state == IDLE); a req_valid while busy SHALL be ignored.
REQ-014 Counters SHALL be sized so that BLOCK_SIZE*BLOCK_SIZE = 4096 bytes is counted exactly, with no overflow.

Reset
REQ-015 On rst_n=0, at any time including mid-frame or mid-RECV, the block SHALL enter IDLE, and tx_start, pix_valid, done and error SHALL be 0.
REQ-016 On reset, tx_data, pix_x, pix_y, pix_count and the latched coordinates SHALL be 0; no partial frame SHALL resume.

Configuration
REQ-017 With REQ_TIMEOUT_EN defined, the block SHALL count idle cycles in RECV, restarting the count on each rx_ready.
- At TIMEOUT_CYCLES, it SHALL set error=1 (held until the next accepted request), skip done, and return to IDLE.
REQ-018 With REQ_TIMEOUT_EN undefined, there SHALL be no watchdog counter, error SHALL be tied to 0, and RECV SHALL wait indefinitely.

Structure
REQ-019 The shared package mandelbrot_pkg SHALL hold CMD_RESET=0, CMD_SEND_BUFFER=1, FRAME_LEN=7 and the state enumeration.
REQ-020 The transmit byte sequencing SHALL be one sub-module, frame_serializer; the rest of the block SHALL be flat.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Request c_real=0xF800, c_imag=0xFC00, c_step=0x0010 -> tx bytes 01 F8 00 FC 00 00 10 in order, each tx_start pulse one cycle long.
- tx_active held high 20 cycles after each start -> no tx_start while tx_active=1, and exactly 7 starts in total.
- Feed 4096 bytes of value (i mod 256) -> pixel i reported at pix_x=i%64, pix_y=i/64; done coincides with pixel (63,63).
- rx_ready strobes during SEND, and req_valid pulsed during RECV -> both ignored; frame and pixel stream unchanged.
- rst_n low after 3 tx bytes -> outputs return to reset values; a new request restarts at byte 0x01.
- REQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, stream stops after 10 bytes -> error=1 at idle cycle 100, no done, req_ready=1.
